aes_round_iter: RTL and testbench

Iterative AES-128 encryption datapath that owns the cipher state register and drives four `table_lookup` instances plus four `S4` instances, one column each, every round. It sits directly upstream of the T-table stage: it presents the ShiftRows-permuted state words, consumes the registered table outputs one cycle later, XORs in the round key and writes the new state back. Round keys come from an external pre-expanded key store indexed by this block.

---
 rtl/aes_round_iter_if.sv | 25 ++
 rtl/aes_round_iter.sv | 256 +++++++++++++++++++++++++
 tb/tb_aes_round_iter.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_round_iter_if.sv
// aes_round_iter_if: plaintext, round-key lookup and ciphertext bundle for aes_round_iter.
// Latency: none, wiring only.
// Backpressure: in_valid/in_ready and out_valid/out_ready handshakes; rk_data answers rk_idx in the same cycle.
interface aes_round_iter_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [3:0]   rk_idx;
    logic [127:0] rk_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    // Cipher core side
    modport slave (
        input  in_valid, in_data, rk_data, out_ready,
        output in_ready, rk_idx, out_valid, out_data
    );

    // Plaintext source, round-key store and ciphertext sink side
    modport master (
        output in_valid, in_data, rk_data, out_ready,
        input  in_ready, rk_idx, out_valid, out_data
    );
endinterface

// File: rtl/aes_round_iter.sv
// aes_round_iter: iterative AES-128 encryptor, one round per LOOK/MIX cycle pair, ten rounds.
// Latency: 21 cycles accept to out_valid; one block per 22 cycles (21 with AES_ROUND_ITER_B2B_EN).
// Backpressure: DONE holds out_valid/out_data until out_ready; in_ready only in IDLE (and DONE, following out_ready, under AES_ROUND_ITER_B2B_EN).
// Optional macro AES_ROUND_ITER_B2B_EN: DONE may hand off the ciphertext and accept the next plaintext in one cycle.

package aes_round_iter_pkg;

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        logic [7:0] y;
        acc = 8'h00;
        x   = a;
        y   = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) begin
                acc = acc ^ x;
            end
            x = xtime(x);
            y = y >> 1;
        end
        return acc;
    endfunction

    // S-box as multiplicative inverse (a^254) followed by the affine map.
    // A pure function of 8 bits, so synthesis collapses it into a 256x8 table.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] inv;
        inv = a;
        // exponent e -> 2e+1 six times takes a^1 to a^127
        for (int i = 0; i < 6; i++) begin
            inv = gf_mul(gf_mul(inv, inv), a);
        end
        inv = gf_mul(inv, inv);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

endpackage

// table_lookup: four T-table words for one ShiftRows-permuted column.
// Latency: 1 cycle, outputs registered.
// Backpressure: none, samples every cycle.
module table_lookup
    import aes_round_iter_pkg::*;
(
    input  logic        i_clk,
    input  logic [31:0] i_word,
    output logic [31:0] o_p0,
    output logic [31:0] o_p1,
    output logic [31:0] o_p2,
    output logic [31:0] o_p3
);
    logic [7:0]  w_s0, w_s1, w_s2, w_s3;
    logic [7:0]  w_x0, w_x1, w_x2, w_x3;
    logic [31:0] r_p0, r_p1, r_p2, r_p3;

    assign w_s0 = sbox(i_word[31:24]);
    assign w_s1 = sbox(i_word[23:16]);
    assign w_s2 = sbox(i_word[15:8]);
    assign w_s3 = sbox(i_word[7:0]);
    assign w_x0 = xtime(w_s0);
    assign w_x1 = xtime(w_s1);
    assign w_x2 = xtime(w_s2);
    assign w_x3 = xtime(w_s3);

    // Register each byte's MixColumns contribution; XOR of the four is the mixed column
    always_ff @(posedge i_clk) begin
        r_p0 <= {w_x0,        w_s0,        w_s0,        w_x0 ^ w_s0};
        r_p1 <= {w_x1 ^ w_s1, w_x1,        w_s1,        w_s1};
        r_p2 <= {w_s2,        w_x2 ^ w_s2, w_x2,        w_s2};
        r_p3 <= {w_s3,        w_s3,        w_x3 ^ w_s3, w_x3};
    end

    assign o_p0 = r_p0;
    assign o_p1 = r_p1;
    assign o_p2 = r_p2;
    assign o_p3 = r_p3;
endmodule

// S4: four parallel S-boxes for the final round (no MixColumns).
// Latency: 1 cycle, output registered.
// Backpressure: none, samples every cycle.
module S4
    import aes_round_iter_pkg::*;
(
    input  logic        i_clk,
    input  logic [31:0] i_word,
    output logic [31:0] o_word
);
    logic [31:0] r_word;

    // Substitute all four bytes in place
    always_ff @(posedge i_clk) begin
        r_word <= {sbox(i_word[31:24]), sbox(i_word[23:16]),
                   sbox(i_word[15:8]),  sbox(i_word[7:0])};
    end

    assign o_word = r_word;
endmodule

module aes_round_iter (
    input logic             clk,
    input logic             rst_n,
    aes_round_iter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOOK = 2'd1,
        MIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [3:0] LAST_RND = 4'd10;

    state_t       r_state, w_state_nxt;
    logic [127:0] r_data,  w_data_nxt;
    logic [3:0]   r_rnd,   w_rnd_nxt;
    logic [3:0]   r_rk_idx, w_rk_idx_nxt;
    logic         w_in_ready;
    logic         w_out_valid;

    logic [31:0]  w_col [4];
    logic [31:0]  w_p0  [4];
    logic [31:0]  w_p1  [4];
    logic [31:0]  w_p2  [4];
    logic [31:0]  w_p3  [4];
    logic [31:0]  w_sb  [4];
    logic [31:0]  w_mix [4];
    logic [127:0] w_round;

    // Column i takes row r from state word (i+r) mod 4: ShiftRows folded into the wiring.
    // Both table sets see the same word; MIX picks which one to use.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_col
            assign w_col[gi] = {r_data[127 - 32*gi           -: 8],
                                r_data[119 - 32*((gi+1) % 4) -: 8],
                                r_data[111 - 32*((gi+2) % 4) -: 8],
                                r_data[103 - 32*((gi+3) % 4) -: 8]};

            table_lookup u_tl (
                .i_clk  (clk),
                .i_word (w_col[gi]),
                .o_p0   (w_p0[gi]),
                .o_p1   (w_p1[gi]),
                .o_p2   (w_p2[gi]),
                .o_p3   (w_p3[gi])
            );

            S4 u_s4 (
                .i_clk  (clk),
                .i_word (w_col[gi]),
                .o_word (w_sb[gi])
            );

            assign w_mix[gi] = (r_rnd == LAST_RND) ? w_sb[gi]
                             : (w_p0[gi] ^ w_p1[gi] ^ w_p2[gi] ^ w_p3[gi]);
        end
    endgenerate

    assign w_round = {w_mix[0], w_mix[1], w_mix[2], w_mix[3]};

    // Next state, datapath updates and handshake outputs
    always_comb begin
        w_state_nxt  = r_state;
        w_data_nxt   = r_data;
        w_rnd_nxt    = r_rnd;
        w_rk_idx_nxt = r_rk_idx;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;

        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    // rk_idx is 0 here, so rk_data is the whitening key
                    w_data_nxt   = bus.in_data ^ bus.rk_data;
                    w_rnd_nxt    = 4'd1;
                    w_rk_idx_nxt = 4'd1;
                    w_state_nxt  = LOOK;
                end
            end

            LOOK: begin
                // Tables capture the current state at the end of this cycle
                w_state_nxt = MIX;
            end

            MIX: begin
                w_data_nxt = w_round ^ bus.rk_data;
                if (r_rnd == LAST_RND) begin
                    // Park rk_idx on key 0 so DONE can whiten a following block
                    w_rk_idx_nxt = 4'd0;
                    w_state_nxt  = DONE;
                end else begin
                    w_rnd_nxt    = r_rnd + 4'd1;
                    w_rk_idx_nxt = r_rk_idx + 4'd1;
                    w_state_nxt  = LOOK;
                end
            end

            DONE: begin
                w_out_valid = 1'b1;
`ifdef AES_ROUND_ITER_B2B_EN
                w_in_ready = bus.out_ready;
                if (bus.out_ready) begin
                    w_rk_idx_nxt = 4'd0;
                    w_state_nxt  = IDLE;
                    if (bus.in_valid) begin
                        w_data_nxt   = bus.in_data ^ bus.rk_data;
                        w_rnd_nxt    = 4'd1;
                        w_rk_idx_nxt = 4'd1;
                        w_state_nxt  = LOOK;
                    end
                end
`else
                if (bus.out_ready) begin
                    w_rk_idx_nxt = 4'd0;
                    w_state_nxt  = IDLE;
                end
`endif
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State register; reset abandons any block in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_data   <= '0;
            r_rnd    <= '0;
            r_rk_idx <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_data   <= w_data_nxt;
            r_rnd    <= w_rnd_nxt;
            r_rk_idx <= w_rk_idx_nxt;
        end
    end

    // Handshakes are held low for the whole time reset is asserted
    assign bus.in_ready  = w_in_ready  & rst_n;
    assign bus.out_valid = w_out_valid & rst_n;
    assign bus.rk_idx    = r_rk_idx;
    assign bus.out_data  = r_data;
endmodule

// File: tb/tb_aes_round_iter.sv
// tb_aes_round_iter: FIPS-197 vectors, stall, mid-block reset and back-to-back issue for aes_round_iter.
// Latency: expects ciphertext 21 cycles after accept.
// Backpressure: holds out_ready low for a stall window; otherwise always ready.
module tb_aes_round_iter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    aes_round_iter_if bus();

    aes_round_iter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
`ifdef AES_ROUND_ITER_B2B_EN
    localparam int SECOND_LAT = 42;
`else
    localparam int SECOND_LAT = 43;
`endif

    localparam logic [2047:0] SBOX_FLAT = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
    localparam logic [79:0] RCON_FLAT = 80'h01020408102040801b36;

    typedef struct {
        logic [127:0] ct;
        int           cyc;
        int           id;
    } exp_t;

    exp_t         exp_q[$];
    exp_t         mon_e;
    logic [127:0] ks [2][11];
    logic         key_sel = 1'b0;
    bit           prev_valid = 1'b0;
    int           checks = 0;
    int           errors = 0;

    // Round-key store: combinational answer to rk_idx
    assign bus.rk_data = (bus.rk_idx <= 4'd10) ? ks[key_sel][bus.rk_idx] : 128'h0;

    function automatic logic [7:0] tb_sbox(input logic [7:0] a);
        logic [2047:0] t;
        t = SBOX_FLAT;
        return t[2047 - 8*int'(a) -: 8];
    endfunction

    task automatic expand(input int sel, input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [79:0] rc;
        rc = RCON_FLAT;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {tb_sbox(t[23:16]), tb_sbox(t[15:8]), tb_sbox(t[7:0]), tb_sbox(t[31:24])}
                    ^ {rc[79 - 8*(i/4 - 1) -: 8], 24'h0};
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) ks[sel][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic check1(input string name, input logic got, input logic req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %b, required %b (cycle %0d)", name, got, req, cyc);
        end
    endtask

    task automatic check4(input string name, input logic [3:0] got, input logic [3:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, got, req, cyc);
        end
    endtask

    task automatic check128(input string name, input logic [127:0] got, input logic [127:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, got, req, cyc);
        end
    endtask

    task automatic checkint(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    // Monitor: each new ciphertext presentation is matched against the scoreboard
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got out_data=%h at cycle %0d, required no output",
                         bus.out_data, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check128($sformatf("ct_blk%0d", mon_e.id), bus.out_data, mon_e.ct);
                checkint($sformatf("out_cycle_blk%0d", mon_e.id), cyc, mon_e.cyc);
            end
        end
        prev_valid = rst_n && bus.out_valid;
    end

    // Called at a negedge with the DUT idle; offers one plaintext for one cycle
    task automatic send(input logic [127:0] pt, input logic ksel, input logic [127:0] ct,
                        input bit expect_out, input int id);
        exp_t e;
        bus.in_data  = pt;
        key_sel      = ksel;
        bus.in_valid = 1'b1;
        check1($sformatf("accept_ready_blk%0d", id), bus.in_ready, 1'b1);
        if (expect_out) begin
            e.ct  = ct;
            e.cyc = cyc + 21;
            e.id  = id;
            exp_q.push_back(e);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles, input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && bus.in_ready && !bus.out_valid) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got %0d outputs pending after %0d cycles, required 0",
                     name, exp_q.size(), max_cycles);
            exp_q.delete();
        end
    endtask

    task automatic wait_valid(input int max_cycles, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got out_valid=0 for %0d cycles, required 1", name, max_cycles);
        end
    endtask

    initial begin
        int n0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        expand(0, KEY_B);
        expand(1, KEY_C);

        // Reset values
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check1("rst_in_ready", bus.in_ready, 1'b0);
        check1("rst_out_valid", bus.out_valid, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check1("idle_in_ready", bus.in_ready, 1'b1);
        check1("idle_out_valid", bus.out_valid, 1'b0);
        check4("idle_rk_idx", bus.rk_idx, 4'd0);
        check128("idle_out_data", bus.out_data, 128'h0);

        // FIPS-197 App. B
        send(PT_B, 1'b0, CT_B, 1'b1, 1);
        wait_idle(40, "appb");

        // FIPS-197 App. C.1 with round-key index trace
        bus.in_data  = PT_C;
        key_sel      = 1'b1;
        bus.in_valid = 1'b1;
        check1("accept_ready_blk2", bus.in_ready, 1'b1);
        begin
            exp_t e;
            e.ct = CT_C; e.cyc = cyc + 21; e.id = 2;
            exp_q.push_back(e);
        end
        check4("rk_idx_c0", bus.rk_idx, 4'd0);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) bus.in_valid = 1'b0;
            check4($sformatf("rk_idx_c%0d", k), bus.rk_idx, 4'((k + 1) / 2));
        end
        wait_idle(40, "appc");

        // Output stall: 15 cycles in DONE with out_ready low, competing plaintext offered
        bus.out_ready = 1'b0;
        send(PT_B, 1'b0, CT_B, 1'b1, 3);
        wait_valid(40, "stall");
        for (int s = 0; s < 15; s++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = PT_C;
            check1($sformatf("stall_out_valid_%0d", s), bus.out_valid, 1'b1);
            check128($sformatf("stall_out_data_%0d", s), bus.out_data, CT_B);
            check1($sformatf("stall_in_ready_%0d", s), bus.in_ready, 1'b0);
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check1("post_stall_out_valid", bus.out_valid, 1'b0);
        check1("post_stall_in_ready", bus.in_ready, 1'b1);

        // Reset in cycle 9 of an encryption, then a clean App. B block
        send(PT_C, 1'b1, CT_C, 1'b0, 4);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check1("midrst_out_valid", bus.out_valid, 1'b0);
        check128("midrst_out_data", bus.out_data, 128'h0);
        check4("midrst_rk_idx", bus.rk_idx, 4'd0);
        check1("midrst_in_ready", bus.in_ready, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        send(PT_B, 1'b0, CT_B, 1'b1, 5);
        wait_idle(40, "post_reset");

        // Two blocks with in_valid and out_ready held high
        n0 = cyc;
        bus.out_ready = 1'b1;
        bus.in_data   = PT_B;
        key_sel       = 1'b0;
        bus.in_valid  = 1'b1;
        check1("accept_ready_blk6", bus.in_ready, 1'b1);
        begin
            exp_t e;
            e.ct = CT_B; e.cyc = n0 + 21; e.id = 6;
            exp_q.push_back(e);
            e.ct = CT_C; e.cyc = n0 + SECOND_LAT; e.id = 7;
            exp_q.push_back(e);
        end
        wait_valid(40, "b2b_first");
        bus.in_data = PT_C;
        key_sel     = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (bus.in_ready) begin
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        wait_idle(60, "b2b");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by time %0t, required finish", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
